// File: rtl/fifo_uart_tx.sv
// Consumer end of a small byte FIFO: pops one byte at a time and sends it
// as an 8N1 serial frame (start 0, 8 data bits LSB first, stop 1).
module fifo_uart_tx #(
    parameter int DATA_W       = 8,
    parameter int CLKS_PER_BIT = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              enable,
    input  logic              fifo_empty,
    input  logic [DATA_W-1:0] fifo_data,
    output logic              fifo_pop,
    output logic              tx,
    output logic              busy,
    output logic              tx_done
);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_POP   = 3'd1;
    localparam logic [2:0] S_LOAD  = 3'd2;
    localparam logic [2:0] S_START = 3'd3;
    localparam logic [2:0] S_DATA  = 3'd4;
    localparam logic [2:0] S_STOP  = 3'd5;

    localparam logic [15:0] BAUD_LAST = 16'(CLKS_PER_BIT - 1);
    localparam logic [2:0]  BIT_LAST  = 3'(DATA_W - 1);

    logic [2:0]        state_q, state_d;
    logic [15:0]       baud_q, baud_d;
    logic [2:0]        bit_q, bit_d;
    logic [DATA_W-1:0] shift_q, shift_d;
    logic              tx_q, tx_d;
    logic              pop_q, pop_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              baud_tc_s;

    assign baud_tc_s = (baud_q == BAUD_LAST);

    // State, counters, datapath and output registers
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
            baud_q  <= 16'd0;
            bit_q   <= 3'd0;
            shift_q <= '0;
            tx_q    <= 1'b1;
            pop_q   <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            baud_q  <= baud_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
            tx_q    <= tx_d;
            pop_q   <= pop_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    // Next-state, counter and shift-register logic
    always_comb begin
        state_d = state_q;
        baud_d  = baud_q;
        bit_d   = bit_q;
        shift_d = shift_q;
        case (state_q)
            S_IDLE: begin
                if (enable && !fifo_empty) begin
                    state_d = S_POP;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_POP: begin
                state_d = S_LOAD;
            end
            S_LOAD: begin
                // FIFO read data is valid one cycle after the pop strobe
                shift_d = fifo_data;
                baud_d  = 16'd0;
                state_d = S_START;
            end
            S_START: begin
                if (baud_tc_s) begin
                    baud_d  = 16'd0;
                    bit_d   = 3'd0;
                    state_d = S_DATA;
                end else begin
                    baud_d = baud_q + 16'd1;
                end
            end
            S_DATA: begin
                if (baud_tc_s) begin
                    baud_d  = 16'd0;
                    shift_d = shift_q >> 1;
                    bit_d   = bit_q + 3'd1;
                    if (bit_q == BIT_LAST) begin
                        state_d = S_STOP;
                    end else begin
                        state_d = S_DATA;
                    end
                end else begin
                    baud_d = baud_q + 16'd1;
                end
            end
            S_STOP: begin
                if (baud_tc_s) begin
                    baud_d  = 16'd0;
                    state_d = S_IDLE;
                end else begin
                    baud_d = baud_q + 16'd1;
                end
            end
            default: begin
                state_d = S_IDLE;
                baud_d  = 16'd0;
                bit_d   = 3'd0;
            end
        endcase
    end

    // Outputs are decoded from the next state so they register in step with it
    always_comb begin
        tx_d   = 1'b1;
        pop_d  = 1'b0;
        busy_d = (state_d != S_IDLE);
        done_d = 1'b0;
        case (state_d)
            S_IDLE:  tx_d = 1'b1;
            S_POP:   pop_d = 1'b1;
            S_LOAD:  tx_d = 1'b1;
            S_START: tx_d = 1'b0;
            S_DATA:  tx_d = shift_d[0];
            S_STOP:  done_d = (baud_d == BAUD_LAST);
            default: tx_d = 1'b1;
        endcase
    end

    assign tx       = tx_q;
    assign fifo_pop = pop_q;
    assign busy     = busy_q;
    assign tx_done  = done_q;

endmodule

// File: tb/tb_fifo_uart_tx.sv
// Bench for fifo_uart_tx: FIFO model feeding the DUT, a serial-line decoder
// checking bytes against a scoreboard queue, and per-cycle output checks.
module tb_fifo_uart_tx;

    localparam int CPB   = 4;
    localparam int FRAME = 3 + 10 * CPB;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       enable = 1'b0;
    logic       fifo_empty = 1'b1;
    logic [7:0] fifo_data = 8'd0;
    logic       fifo_pop, tx, busy, tx_done;

    int tests = 0;
    int fails = 0;
    int pops = 0;
    int dones = 0;
    int frames = 0;
    logic [7:0] fifo_q[$];
    logic [7:0] exp_q[$];

    fifo_uart_tx #(.DATA_W(8), .CLKS_PER_BIT(CPB)) dut (
        .clk(clk), .reset(reset), .enable(enable), .fifo_empty(fifo_empty),
        .fifo_data(fifo_data), .fifo_pop(fifo_pop), .tx(tx), .busy(busy),
        .tx_done(tx_done)
    );

    always #5 clk = ~clk;

    // FIFO model: pop serviced on the falling edge, data valid well before LOAD ends
    always @(negedge clk) begin
        if (fifo_pop === 1'b1) begin
            tests++;
            if (fifo_q.size() == 0) begin
                fails++;
                $display("FAIL pop_on_empty: got pop with 0 entries, required no pop");
            end else begin
                fifo_data = fifo_q.pop_front();
            end
        end
        fifo_empty = (fifo_q.size() == 0);
    end

    // Line decoder and event counters
    int mst = 0;
    int mcnt = 0;
    logic [7:0] mbyte = 8'd0;
    logic [7:0] mexp;
    always @(negedge clk) begin
        if (fifo_pop === 1'b1) pops++;
        if (tx_done === 1'b1) dones++;
        if (reset) begin
            mst = 0;
        end else if (mst == 0) begin
            if (tx === 1'b0) begin
                mst = 1;
                mcnt = 0;
                mbyte = 8'd0;
            end
        end else begin
            mcnt++;
            if (mcnt == CPB / 2) begin
                tests++;
                if (tx !== 1'b0) begin
                    fails++;
                    $display("FAIL start_bit: got tx=%b, required 0", tx);
                    mst = 0;
                end
            end else if (mcnt < 9 * CPB && (mcnt % CPB) == CPB / 2) begin
                mbyte = {tx, mbyte[7:1]};
            end else if (mcnt == 9 * CPB + CPB / 2) begin
                frames++;
                tests++;
                mexp = (exp_q.size() != 0) ? exp_q.pop_front() : 8'hxx;
                if (tx !== 1'b1 || mbyte !== mexp) begin
                    fails++;
                    $display("FAIL rx_byte: got byte %h stop %b, required byte %h stop 1",
                             mbyte, tx, mexp);
                end
                mst = 0;
            end
        end
    end

    function automatic logic [3:0] exp_vec(int j, logic [7:0] b);
        logic pop_e, busy_e, tx_e, done_e;
        pop_e  = (j == 1);
        busy_e = (j >= 1 && j <= FRAME - 1);
        done_e = (j == FRAME - 1);
        if (j >= 3 && j < 3 + CPB) tx_e = 1'b0;
        else if (j >= 3 + CPB && j < 3 + 9 * CPB) tx_e = b[(j - 3 - CPB) / CPB];
        else tx_e = 1'b1;
        return {pop_e, busy_e, tx_e, done_e};
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [7:0] b);
        fifo_q.push_back(b);
        exp_q.push_back(b);
    endtask

    task automatic check_frame_cycle(input string name, input int j, input logic [7:0] b);
        logic [3:0] e;
        e = exp_vec(j, b);
        tests++;
        if ({fifo_pop, busy, tx, tx_done} !== e) begin
            fails++;
            $display("FAIL %s cyc %0d: got pop/busy/tx/done=%b, required %b",
                     name, j, {fifo_pop, busy, tx, tx_done}, e);
        end
    endtask

    task automatic wait_frames(input int target, input int budget);
        for (int i = 0; i < budget; i++) begin
            if (frames >= target && busy === 1'b0) break;
            step();
        end
        tests++;
        if (frames < target || busy !== 1'b0) begin
            fails++;
            $display("FAIL wait_frames: got %0d frames busy=%b, required %0d idle",
                     frames, busy, target);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        enable = 1'b1;
        step();
        step();
        reset = 1'b0;
        for (int i = 0; i < 50; i++) begin
            tests++;
            if ({fifo_pop, busy, tx, tx_done} !== 4'b0010) begin
                fails++;
                $display("FAIL reset_idle cyc %0d: got %b, required 0010",
                         i, {fifo_pop, busy, tx, tx_done});
            end
            step();
        end
    endtask

    task automatic test_single();
        int p0, d0;
        p0 = pops;
        d0 = dones;
        enable = 1'b1;
        push(8'hA5);
        for (int j = 1; j <= FRAME + 2; j++) begin
            step();
            check_frame_cycle("single", j, 8'hA5);
        end
        tests++;
        if (pops - p0 != 1 || dones - d0 != 1) begin
            fails++;
            $display("FAIL single_counts: got pops %0d dones %0d, required 1 1",
                     pops - p0, dones - d0);
        end
    endtask

    task automatic test_back_to_back();
        logic [7:0] bytes [3];
        int p0, k;
        bytes[0] = 8'h05;
        bytes[1] = 8'h09;
        bytes[2] = 8'h2D;
        p0 = pops;
        enable = 1'b1;
        for (int i = 0; i < 3; i++) push(bytes[i]);
        for (int j = 1; j <= 3 * FRAME + 2; j++) begin
            step();
            k = (j - 1) / FRAME;
            if (k > 2) k = 2;
            check_frame_cycle("b2b", j - k * FRAME, bytes[k]);
        end
        tests++;
        if (pops - p0 != 3 || fifo_empty !== 1'b1) begin
            fails++;
            $display("FAIL b2b_counts: got pops %0d empty %b, required 3 1",
                     pops - p0, fifo_empty);
        end
    endtask

    task automatic test_enable_gating();
        int p0, f0;
        p0 = pops;
        f0 = frames;
        enable = 1'b0;
        push(8'h64);
        repeat (20) step();
        tests++;
        if (pops != p0 || busy !== 1'b0) begin
            fails++;
            $display("FAIL gate_idle: got pops %0d busy %b, required %0d 0", pops, busy, p0);
        end
        enable = 1'b1;
        step();
        repeat (14) step();
        enable = 1'b0;
        wait_frames(f0 + 1, 100);
        push(8'h3C);
        repeat (30) step();
        tests++;
        if (pops != p0 + 1 || busy !== 1'b0) begin
            fails++;
            $display("FAIL gate_hold: got pops %0d busy %b, required %0d 0",
                     pops, busy, p0 + 1);
        end
        enable = 1'b1;
        wait_frames(f0 + 2, 100);
        tests++;
        if (pops != p0 + 2) begin
            fails++;
            $display("FAIL gate_resume: got pops %0d, required %0d", pops, p0 + 2);
        end
    endtask

    task automatic test_reset_mid_frame();
        int p0, d0, f0;
        p0 = pops;
        d0 = dones;
        f0 = frames;
        enable = 1'b1;
        push(8'h5A);
        for (int j = 1; j <= 20; j++) begin
            step();
            check_frame_cycle("rst_mid", j, 8'h5A);
        end
        reset = 1'b1;
        void'(exp_q.pop_back());
        step();
        tests++;
        if ({fifo_pop, busy, tx, tx_done} !== 4'b0010) begin
            fails++;
            $display("FAIL rst_mid_out: got %b, required 0010", {fifo_pop, busy, tx, tx_done});
        end
        reset = 1'b0;
        repeat (5) step();
        tests++;
        if (dones != d0 || pops != p0 + 1 || busy !== 1'b0) begin
            fails++;
            $display("FAIL rst_mid_quiet: got dones %0d pops %0d busy %b, required %0d %0d 0",
                     dones, pops, busy, d0, p0 + 1);
        end
        push(8'hC3);
        wait_frames(f0 + 1, 100);
        tests++;
        if (pops != p0 + 2 || dones != d0 + 1) begin
            fails++;
            $display("FAIL rst_mid_after: got pops %0d dones %0d, required %0d %0d",
                     pops, dones, p0 + 2, d0 + 1);
        end
    endtask

    task automatic test_full_drain();
        int p0, f0;
        p0 = pops;
        f0 = frames;
        enable = 1'b0;
        for (int i = 0; i < 4; i++) push(8'($urandom_range(0, 255)));
        repeat (5) step();
        enable = 1'b1;
        wait_frames(f0 + 4, 5 * FRAME);
        tests++;
        if (pops != p0 + 4 || fifo_empty !== 1'b1) begin
            fails++;
            $display("FAIL drain: got pops %0d empty %b, required %0d 1",
                     pops, fifo_empty, p0 + 4);
        end
        repeat (20) step();
        tests++;
        if (pops != p0 + 4 || exp_q.size() != 0) begin
            fails++;
            $display("FAIL drain_extra: got pops %0d pending %0d, required %0d 0",
                     pops, exp_q.size(), p0 + 4);
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_enable_gating();
        test_reset_mid_frame();
        test_full_drain();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

endmodule
